// File: rtl/cmp_digit_if.sv
// Handshake and readback bundle between a digit producer and cmp_digit_sequencer.
// The master drives digit flags and control; the slave returns the chained result and tallies.
interface cmp_digit_if #(
  parameter int NUM_DIGITS = 4,
  parameter int TALLY_W    = 8
);
  localparam int IDX_W = $clog2(NUM_DIGITS + 1);

  logic               ena;
  logic               start;
  logic               digit_valid;
  logic               digit_gt;
  logic               digit_eq;
  logic               digit_lt;
  logic               tally_clr;
  logic [1:0]         tally_sel;
  logic               busy;
  logic               done;
  logic               res_gt;
  logic               res_eq;
  logic               res_lt;
  logic               res_err;
  logic [IDX_W-1:0]   digit_idx;
  logic [TALLY_W-1:0] tally_out;

  modport master (
    output ena, start, digit_valid, digit_gt, digit_eq, digit_lt, tally_clr, tally_sel,
    input  busy, done, res_gt, res_eq, res_lt, res_err, digit_idx, tally_out
  );

  modport slave (
    input  ena, start, digit_valid, digit_gt, digit_eq, digit_lt, tally_clr, tally_sel,
    output busy, done, res_gt, res_eq, res_lt, res_err, digit_idx, tally_out
  );
endinterface

// File: rtl/cmp_digit_sequencer.sv
// Chains MSB-first one-hot digit compare flags into a wide-operand verdict and
// keeps saturating per-outcome tallies for self-test readback.
module cmp_digit_sequencer #(
  parameter int NUM_DIGITS = 4,
  parameter int TALLY_W    = 8
) (
  input logic         clk,
  input logic         rst_n,
  cmp_digit_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_DIGITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_e;

  // Tally slots line up with the tally_sel readback encoding.
  typedef enum logic [1:0] {
    T_GT  = 2'd0,
    T_EQ  = 2'd1,
    T_LT  = 2'd2,
    T_ERR = 2'd3
  } tally_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               decided_q, decided_d;
  logic               verdict_gt_q, verdict_gt_d;
  logic               res_gt_q, res_gt_d;
  logic               res_eq_q, res_eq_d;
  logic               res_lt_q, res_lt_d;
  logic               res_err_q, res_err_d;
  logic [TALLY_W-1:0] tally_q [4];
  logic [TALLY_W-1:0] tally_d [4];
  logic [TALLY_W-1:0] tally_out_q, tally_out_d;

  logic [2:0] flags;
  logic       one_hot;
  tally_e     outcome;

  assign flags   = {bus.digit_gt, bus.digit_eq, bus.digit_lt};
  assign one_hot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);

  always_comb begin
    if (res_err_q)     outcome = T_ERR;
    else if (res_lt_q) outcome = T_LT;
    else if (res_eq_q) outcome = T_EQ;
    else               outcome = T_GT;
  end

  // NOTE: every _d gets a hold default before any branch so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    decided_d    = decided_q;
    verdict_gt_d = verdict_gt_q;
    res_gt_d     = res_gt_q;
    res_eq_d     = res_eq_q;
    res_lt_d     = res_lt_q;
    res_err_d    = res_err_q;
    tally_d      = tally_q;
    tally_out_d  = tally_out_q;

    if (bus.ena) begin
      tally_out_d = tally_q[bus.tally_sel];

      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d      = S_SCAN;
            idx_d        = '0;
            decided_d    = 1'b0;
            verdict_gt_d = 1'b0;
          end
        end

        S_SCAN: begin
          if (bus.digit_valid) begin
            idx_d = idx_q + IDX_W'(1);
            if (!one_hot) begin
              state_d   = S_DONE;
              res_gt_d  = 1'b0;
              res_eq_d  = 1'b0;
              res_lt_d  = 1'b0;
              res_err_d = 1'b1;
            end else begin
              // The first non-equal digit from the MSB side fixes the verdict.
              if (!decided_q && (bus.digit_gt || bus.digit_lt)) begin
                decided_d    = 1'b1;
                verdict_gt_d = bus.digit_gt;
              end
              if (idx_d == IDX_W'(NUM_DIGITS)) begin
                state_d   = S_DONE;
                res_gt_d  = decided_d && verdict_gt_d;
                res_lt_d  = decided_d && !verdict_gt_d;
                res_eq_d  = !decided_d;
                res_err_d = 1'b0;
              end
            end
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
          if (tally_q[outcome] != '1) begin
            tally_d[outcome] = tally_q[outcome] + TALLY_W'(1);
          end
        end

        default: state_d = S_IDLE;
      endcase

      if (bus.tally_clr) begin
        for (int i = 0; i < 4; i++) tally_d[i] = '0;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      decided_q    <= 1'b0;
      verdict_gt_q <= 1'b0;
      res_gt_q     <= 1'b0;
      res_eq_q     <= 1'b0;
      res_lt_q     <= 1'b0;
      res_err_q    <= 1'b0;
      tally_out_q  <= '0;
      // NOTE: the tally array is small flop storage, not RAM, so it is reset
      // here; an abort must leave every counter at zero.
      for (int i = 0; i < 4; i++) tally_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      decided_q    <= decided_d;
      verdict_gt_q <= verdict_gt_d;
      res_gt_q     <= res_gt_d;
      res_eq_q     <= res_eq_d;
      res_lt_q     <= res_lt_d;
      res_err_q    <= res_err_d;
      tally_out_q  <= tally_out_d;
      for (int i = 0; i < 4; i++) tally_q[i] <= tally_d[i];
    end
  end

  assign bus.busy      = (state_q == S_SCAN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.res_gt    = res_gt_q;
  assign bus.res_eq    = res_eq_q;
  assign bus.res_lt    = res_lt_q;
  assign bus.res_err   = res_err_q;
  assign bus.digit_idx = idx_q;
  assign bus.tally_out = tally_out_q;
endmodule

// File: doc/cmp_digit_sequencer.md
Name: cmp_digit_sequencer

Overview:
Downstream consumer of the 2-bit magnitude comparator's one-hot gt/eq/lt outputs. It chains per-digit results, presented MSB digit first over successive cycles, into one wide-operand compare result (default 4 digits = 8-bit operands). It also keeps saturating tallies of final outcomes for on-chip self-test readback.

Parameters:
NUM_DIGITS, 4, number of 2-bit digits per compare (>=1); result width equals 2*NUM_DIGITS bits of operand
TALLY_W, 8, width of each outcome tally counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; when 0 all state and counters hold
start  input  1  begin a new compare; sampled only in IDLE
digit_valid  input  1  digit flags valid this cycle
digit_gt  input  1  digit A>B flag from comparator
digit_eq  input  1  digit A==B flag from comparator
digit_lt  input  1  digit A<B flag from comparator
tally_clr  input  1  synchronous clear of all tallies
tally_sel  input  2  tally readback select: 0=gt, 1=eq, 2=lt, 3=err
busy  output  1  high in SCAN
done  output  1  one-cycle pulse when result registers update
res_gt  output  1  final A>B
res_eq  output  1  final A==B
res_lt  output  1  final A<B
res_err  output  1  compare aborted on non-one-hot digit
digit_idx  output  clog2(NUM_DIGITS+1)  digits consumed in current or last compare
tally_out  output  TALLY_W  selected tally value

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, res_*=0, digit_idx=0, all tallies=0, tally_out=0.
- All updates occur on rising clk only when ena=1; ena=0 freezes everything, including done.
- FSM states: IDLE, SCAN, DONE.
- IDLE: start=1 -> SCAN; clear digit_idx and the internal decided/verdict registers. Result outputs keep their previous values until DONE.
- SCAN, busy=1; each cycle with digit_valid=1:
  - Flags not exactly one-hot (000, 011, 101, 110, 111) -> set err; go to DONE immediately; digit_idx holds the count including the bad digit.
  - Otherwise digit_idx++. If undecided and gt or lt is set, latch that verdict as decided. Once decided, later digits are consumed and checked for one-hot but never change the verdict.
  - When digit_idx reaches NUM_DIGITS -> DONE.
  - digit_valid=0: no change; stalls are unlimited.
  - start is ignored while in SCAN.
- DONE (exactly one cycle): done=1; res_* registered from the verdict. Undecided and no err -> res_eq=1. err -> res_err=1 and the other res_* = 0. Exactly one res_* is high. Next state is IDLE. A start asserted during DONE is ignored.
- Latency: a compare with no stalls and no error takes NUM_DIGITS SCAN cycles plus 1 DONE cycle. done is high on cycle NUM_DIGITS+1 after start is sampled.
- Tallies: on the DONE cycle, increment the counter matching the result; each saturates at 2^TALLY_W-1.
- tally_clr=1 clears all tallies. If clear and increment land in the same cycle, clear wins.
- tally_out is a registered copy of the selected counter, updated every enabled cycle; it reflects tally_sel one cycle later.
- Reset mid-SCAN aborts the compare: no done pulse, and tallies are cleared.

Test Plan:
- A=0xB4, B=0xB1 as digits (2,2),(3,3),(1,0),(0,1) MSB first, no stalls -> done on cycle 5 after start; res_gt=1; gt tally=1.
- A=B=0x5A, digits all eq -> res_eq=1, digit_idx=4; then A=0x3F vs B=0xC0 -> first digit lt; the following gt digit is ignored; res_lt=1.
- Digit flags 011 on digit 2 -> done on the next cycle; res_err=1, digit_idx=2, err tally=1, res_gt/eq/lt=0.
- digit_valid low for 3 cycles mid-SCAN and ena low for 2 cycles -> busy stays 1, digit_idx frozen; result is identical to the no-stall run, with done delayed by 5 cycles.
- 260 consecutive eq compares -> eq tally saturates at 255. Then tally_clr coincident with a done -> tally reads 0 with tally_sel=1 one cycle later.
- rst_n pulsed low after digit 2 -> all outputs 0 immediately (async); no done. A fresh start then completes normally.
